// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 core arbiter.
package sha256_pkg;

    // Arbiter ownership phases: idle, streaming the owner's beats, waiting for its digest.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    // Beat mode encodings seen on the sha256 in_mode_i port.
    localparam logic [1:0] MODE_CONT = 2'b00;
    localparam logic [1:0] MODE_INIT = 2'b01;

endpackage

// File: rtl/sha256_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic found;
    int   idx;

    // Scan requesters in rotated order starting at the pointer, grant the first one set.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one sha256 core between N_REQ requesters, one whole message at a time:
// the owner keeps the core from its first beat until its digest is handed over.
module sha256_arbiter
    import sha256_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int I_WIDTH = 64,
    parameter int O_WIDTH = 512
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [N_REQ-1:0][1:0]           req_mode_i,
    input  logic [N_REQ-1:0]                req_last_i,
    input  logic [N_REQ-1:0][I_WIDTH-1:0]   req_data_i,
    input  logic [N_REQ-1:0]                req_valid_i,
    output logic [N_REQ-1:0]                req_ready_o,
    output logic [O_WIDTH-1:0]              rsp_data_o,
    output logic [N_REQ-1:0]                rsp_valid_o,
    input  logic [N_REQ-1:0]                rsp_ready_i,
    output logic [1:0]                      core_mode_o,
    output logic                            core_last_o,
    output logic [I_WIDTH-1:0]              core_data_o,
    output logic                            core_valid_o,
    input  logic                            core_ready_i,
    input  logic [O_WIDTH-1:0]              core_data_i,
    input  logic                            core_valid_i,
    output logic                            core_ready_o,
    output logic [N_REQ-1:0]                grant_o,
    output logic                            err_o
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic              first_q, first_d;
    logic              err_q,   err_d;

    logic [N_REQ-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;

    logic              own_valid;
    logic [1:0]        own_mode;
    logic              own_last;
    logic [I_WIDTH-1:0] own_data;
    logic              own_rsp_ready;
    logic              beat_fire;
    logic              rsp_fire;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick)
    );

    // Convert the one-hot round-robin pick into the owner index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Select the current owner's request and response-side signals.
    always_comb begin
        own_valid     = req_valid_i[owner_q];
        own_mode      = req_mode_i[owner_q];
        own_last      = req_last_i[owner_q];
        own_data      = req_data_i[owner_q];
        own_rsp_ready = rsp_ready_i[owner_q];
        beat_fire     = (state_q == STREAM) && own_valid && core_ready_i;
        rsp_fire      = (state_q == WAIT) && core_valid_i && own_rsp_ready;
    end

    // State register: FSM, owner, grant, rr pointer, first-beat flag and error pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant a whole message, stream it, then wait for the digest handshake.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A digest arriving while nobody waits for one is dropped and flagged.
                if (core_valid_i) begin
                    err_d = 1'b1;
                end
                if (|req_valid_i) begin
                    state_d = STREAM;
                    owner_d = pick_idx;
                    grant_d = pick;
                    first_d = 1'b1;
                end
            end
            STREAM: begin
                if (core_valid_i) begin
                    err_d = 1'b1;
                end
                if (beat_fire) begin
                    first_d = 1'b0;
                    // The opening beat must start a message; it is still forwarded as-is.
                    if (first_q && (own_mode == MODE_CONT)) begin
                        err_d = 1'b1;
                    end
                    if (own_last) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: route the owner's stream to the core and the digest back to the owner.
    always_comb begin
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        core_valid_o = 1'b0;
        core_mode_o  = MODE_CONT;
        core_last_o  = 1'b0;
        core_data_o  = '0;
        core_ready_o = 1'b0;
        case (state_q)
            STREAM: begin
                core_valid_o         = own_valid;
                core_mode_o          = first_q ? own_mode : MODE_CONT;
                core_last_o          = own_last;
                core_data_o          = own_data;
                req_ready_o[owner_q] = core_ready_i;
                core_ready_o         = core_valid_i;
            end
            WAIT: begin
                rsp_valid_o[owner_q] = core_valid_i;
                core_ready_o         = own_rsp_ready;
            end
            default: begin
                core_ready_o = core_valid_i;
            end
        endcase
        rsp_data_o = core_data_i;
        grant_o    = grant_q;
        err_o      = err_q;
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter with a small stand-in core model.
module tb_sha256_arbiter;
    import sha256_pkg::*;

    localparam int N  = 4;
    localparam int IW = 64;
    localparam int OW = 512;

    logic                 clk = 1'b0;
    logic                 rst_n_i;
    logic [N-1:0][1:0]    req_mode_i;
    logic [N-1:0]         req_last_i;
    logic [N-1:0][IW-1:0] req_data_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [OW-1:0]        rsp_data_o;
    logic [N-1:0]         rsp_valid_o;
    logic [N-1:0]         rsp_ready_i;
    logic [1:0]           core_mode_o;
    logic                 core_last_o;
    logic [IW-1:0]        core_data_o;
    logic                 core_valid_o;
    logic                 core_ready_i;
    logic [OW-1:0]        core_data_i;
    logic                 core_valid_i;
    logic                 core_ready_o;
    logic [N-1:0]         grant_o;
    logic                 err_o;

    always #5 clk = ~clk;

    sha256_arbiter #(.N_REQ(N), .I_WIDTH(IW), .O_WIDTH(OW)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .req_mode_i(req_mode_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .core_mode_o(core_mode_o), .core_last_o(core_last_o), .core_data_o(core_data_o),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
        .grant_o(grant_o), .err_o(err_o)
    );

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  gnt;
        logic [1:0]  mode;
        logic        last;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [3:0]   vld;
        logic [511:0] data;
    } rsp_t;

    beat_t blog[$];
    rsp_t  rlog[$];

    // requester drivers
    int         rem[N], bidx[N], nb[N], msg[N], more[N];
    logic [1:0] m0[N];
    // core model
    logic [63:0]  acc;
    int           ccnt, cdly, cyc, err_cnt;
    bit           cpend, spur, stall;
    logic [511:0] cdig;
    int           errors = 0, checks = 0;

    function automatic logic [63:0] beat_data(int r, int m, int b);
        return {4'h0, 4'(1 << r), 8'(m), 16'hA5C3, 32'(b)};
    endfunction

    function automatic logic [511:0] mk_dig(logic [63:0] a, int n);
        return {a, 64'(n), {6{~a}}};
    endfunction

    function automatic logic [511:0] golden(int r, int m, int n);
        logic [63:0] a = '0;
        for (int b = 0; b < n; b++) a = {a[62:0], a[63]} ^ beat_data(r, m, b);
        return mk_dig(a, n);
    endfunction

    function automatic rsp_t get_rsp(int k);
        rsp_t e;
        e.vld = '0; e.data = '0;
        if (rlog.size() > k) e = rlog[k];
        return e;
    endfunction

    function automatic beat_t get_beat(int k);
        beat_t e;
        e.src = '0; e.gnt = '0; e.mode = '0; e.last = 1'b0; e.data = '0;
        if (blog.size() > k) e = blog[k];
        return e;
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_valid_i[r] = rem[r] > 0;
            req_data_i[r]  = beat_data(r, msg[r], bidx[r]);
            req_mode_i[r]  = (bidx[r] == 0) ? m0[r] : MODE_CONT;
            req_last_i[r]  = (bidx[r] == nb[r] - 1);
        end
        core_valid_i = cpend | spur;
        core_data_i  = spur ? {16{32'hDEADBEEF}} : (cpend ? cdig : '0);
        core_ready_i = stall ? (cyc % 3 != 0) : 1'b1;
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++) begin
            rem[r] = 0; bidx[r] = 0; nb[r] = 1; msg[r] = 0; more[r] = 0; m0[r] = MODE_INIT;
        end
        acc = '0; ccnt = 0; cdly = 0; cpend = 1'b0; spur = 1'b0; stall = 1'b0; cdig = '0;
        rsp_ready_i = '1;
    endtask

    task automatic start_msg(int r, int m, int n, logic [1:0] mode0);
        msg[r] = m; nb[r] = n; rem[r] = n; bidx[r] = 0; m0[r] = mode0; more[r] = 0;
    endtask

    // one clock: sample handshakes at negedge, advance models after posedge
    task automatic tick();
        logic [3:0] fire;
        beat_t      e;
        @(negedge clk);
        for (int r = 0; r < N; r++) fire[r] = req_valid_i[r] & req_ready_o[r];
        if (core_valid_o && core_ready_i) begin
            e.src = core_data_o[59:56]; e.gnt = grant_o; e.mode = core_mode_o;
            e.last = core_last_o; e.data = core_data_o;
            blog.push_back(e);
            acc = {acc[62:0], acc[63]} ^ core_data_o;
            ccnt++;
            if (core_last_o) begin
                cdig = mk_dig(acc, ccnt); acc = '0; ccnt = 0; cdly = 2;
            end
        end
        for (int r = 0; r < N; r++) begin
            if (rsp_valid_o[r] && rsp_ready_i[r]) begin
                rsp_t q;
                q.vld = rsp_valid_o; q.data = rsp_data_o;
                rlog.push_back(q);
            end
        end
        if (err_o) err_cnt++;
        if (cpend && core_valid_i && core_ready_o) cpend = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        spur = 1'b0;
        for (int r = 0; r < N; r++) begin
            if (fire[r]) begin
                bidx[r]++; rem[r]--;
                if (rem[r] == 0 && more[r] > 0) begin
                    more[r]--; msg[r]++; bidx[r] = 0; rem[r] = nb[r];
                end
            end
        end
        if (cdly > 0) begin
            cdly--;
            if (cdly == 0) cpend = 1'b1;
        end
        drive();
    endtask

    task automatic run_rsp(int target, int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rlog.size() >= target) break;
            tick();
        end
        if (rlog.size() >= target) to = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        #1;
        blog.delete(); rlog.delete();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b1;
        clear_model();
        drive();
        rst_n_i = 1'b0;
        #1;
        @(posedge clk); #1;
        checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
        checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
        checks++; if (rsp_valid_o !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); end
        checks++; if ({core_valid_o, core_ready_o, err_o} !== 3'b0) begin errors++; $display("FAIL reset_core_ctl: got %b want 000", {core_valid_o, core_ready_o, err_o}); end
        checks++; if ({core_mode_o, core_last_o, core_data_o} !== 67'b0) begin errors++; $display("FAIL reset_core_beat: got %h want 0", {core_mode_o, core_last_o, core_data_o}); end
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        #1;
        tick();
        checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL idle_no_req_grant: got %b want 0000", grant_o); end
    endtask

    task automatic test_single();
        bit to;
        int bad_src = 0, bad_mode = 0, bad_last = 0, bad_data = 0;
        rsp_t q;
        blog.delete(); rlog.delete();
        start_msg(1, 1, 32, MODE_INIT);
        drive();
        tick();
        checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", grant_o); end
        run_rsp(1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0d want 0", to); end
        checks++; if (blog.size() !== 32) begin errors++; $display("FAIL single_beats: got %0d want 32", blog.size()); end
        for (int i = 0; i < 32; i++) begin
            beat_t e = get_beat(i);
            if (e.src !== 4'b0010 || e.gnt !== 4'b0010) bad_src++;
            if (e.mode !== ((i == 0) ? MODE_INIT : MODE_CONT)) bad_mode++;
            if (e.last !== (i == 31)) bad_last++;
            if (e.data !== beat_data(1, 1, i)) bad_data++;
        end
        checks++; if (bad_src !== 0) begin errors++; $display("FAIL single_src: bad=%0d want 0", bad_src); end
        checks++; if (bad_mode !== 0) begin errors++; $display("FAIL single_mode: bad=%0d want 0", bad_mode); end
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL single_last: bad=%0d want 0", bad_last); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL single_data: bad=%0d want 0", bad_data); end
        q = get_rsp(0);
        checks++; if (q.vld !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b want 0010", q.vld); end
        checks++; if (q.data !== golden(1, 1, 32)) begin errors++; $display("FAIL single_digest: got %h want %h", q.data[511:448], golden(1, 1, 32) >> 448); end
        checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL single_grant_release: got %b want 0000", grant_o); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_all_rr();
        bit to;
        int ord[5] = '{0, 1, 2, 3, 0};
        int mid[5] = '{10, 10, 10, 10, 11};
        int bad_il = 0, bad_ord = 0;
        do_reset();
        stall = 1'b1;
        for (int r = 0; r < N; r++) start_msg(r, 10, 3, MODE_INIT);
        more[0] = 1;
        drive();
        run_rsp(5, 400, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_timeout: got %0d want 0", to); end
        for (int k = 0; k < 5; k++) begin
            rsp_t q = get_rsp(k);
            checks++; if (q.vld !== 4'(1 << ord[k])) begin errors++; $display("FAIL rr_order_%0d: got %b want %b", k, q.vld, 4'(1 << ord[k])); end
            checks++; if (q.data !== golden(ord[k], mid[k], 3)) begin errors++; $display("FAIL rr_digest_%0d: got %h want %h", k, q.data[511:448], golden(ord[k], mid[k], 3) >> 448); end
        end
        checks++; if (blog.size() !== 15) begin errors++; $display("FAIL rr_beats: got %0d want 15", blog.size()); end
        for (int i = 0; i < 15; i++) begin
            beat_t e = get_beat(i);
            if (e.src !== e.gnt) bad_il++;
            if (e.src !== 4'(1 << ord[i / 3])) bad_ord++;
        end
        checks++; if (bad_il !== 0) begin errors++; $display("FAIL rr_interleave: bad=%0d want 0", bad_il); end
        checks++; if (bad_ord !== 0) begin errors++; $display("FAIL rr_beat_owner: bad=%0d want 0", bad_ord); end
        stall = 1'b0;
        drive();
    endtask

    task automatic test_block_other();
        bit to;
        bit leak = 1'b0;
        rsp_t q;
        blog.delete(); rlog.delete();
        start_msg(2, 20, 4, MODE_INIT);
        drive();
        tick(); tick();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL blk_grant2: got %b want 0100", grant_o); end
        start_msg(0, 21, 2, MODE_INIT);
        drive();
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rlog.size() >= 1) begin to = 1'b0; break; end
            if (req_ready_o[0]) leak = 1'b1;
            tick();
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL blk_timeout: got %0d want 0", to); end
        checks++; if (leak !== 1'b0) begin errors++; $display("FAIL blk_ready0_leak: got %0d want 0", leak); end
        q = get_rsp(0);
        checks++; if (q.vld !== 4'b0100) begin errors++; $display("FAIL blk_rsp2: got %b want 0100", q.vld); end
        checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL blk_bubble: got %b want 0000", grant_o); end
        tick();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL blk_grant0: got %b want 0001", grant_o); end
        run_rsp(2, 100, to);
        q = get_rsp(1);
        checks++; if (q.vld !== 4'b0001) begin errors++; $display("FAIL blk_rsp0: got %b want 0001", q.vld); end
        checks++; if (q.data !== golden(0, 21, 2)) begin errors++; $display("FAIL blk_digest0: got %h want %h", q.data[511:448], golden(0, 21, 2) >> 448); end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit = 1'b0;
        rsp_t q;
        blog.delete(); rlog.delete();
        start_msg(1, 30, 16, MODE_INIT);
        drive();
        for (int i = 0; i < 100; i++) begin
            if (bidx[1] == 5) begin hit = 1'b1; break; end
            tick();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_beat5: got %0d want 1", hit); end
        rst_n_i = 1'b0;
        clear_model();
        drive();
        checks++; if ({grant_o, req_ready_o, rsp_valid_o} !== 12'b0) begin errors++; $display("FAIL rstmid_vectors: got %h want 000", {grant_o, req_ready_o, rsp_valid_o}); end
        checks++; if ({core_valid_o, core_ready_o, err_o, core_mode_o, core_last_o, core_data_o} !== 70'b0) begin errors++; $display("FAIL rstmid_core: got %h want 0", {core_valid_o, core_ready_o, err_o, core_mode_o, core_last_o, core_data_o}); end
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        #1;
        blog.delete(); rlog.delete();
        start_msg(0, 31, 3, MODE_INIT);
        start_msg(3, 32, 2, MODE_INIT);
        drive();
        tick();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr0_grant: got %b want 0001", grant_o); end
        run_rsp(2, 100, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %0d want 0", to); end
        q = get_rsp(0);
        checks++; if (q.vld !== 4'b0001 || q.data !== golden(0, 31, 3)) begin errors++; $display("FAIL rstmid_rsp0: got %b/%h want 0001/%h", q.vld, q.data[511:448], golden(0, 31, 3) >> 448); end
        q = get_rsp(1);
        checks++; if (q.vld !== 4'b1000 || q.data !== golden(3, 32, 2)) begin errors++; $display("FAIL rstmid_rsp3: got %b/%h want 1000/%h", q.vld, q.data[511:448], golden(3, 32, 2) >> 448); end
        checks++; if (blog.size() !== 5) begin errors++; $display("FAIL rstmid_beats: got %0d want 5", blog.size()); end
    endtask

    task automatic test_backpressure();
        bit hit = 1'b0;
        int bad_rdy = 0, bad_vld = 0, bad_dat = 0, bad_gnt = 0;
        logic [511:0] gd = golden(3, 40, 3);
        blog.delete(); rlog.delete();
        rsp_ready_i[3] = 1'b0;
        start_msg(3, 40, 3, MODE_INIT);
        drive();
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid_o == 4'b1000) begin hit = 1'b1; break; end
            tick();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL bp_digest_seen: got %0d want 1", hit); end
        for (int i = 0; i < 10; i++) begin
            if (core_ready_o !== 1'b0) bad_rdy++;
            if (rsp_valid_o !== 4'b1000) bad_vld++;
            if (rsp_data_o !== gd) bad_dat++;
            if (grant_o !== 4'b1000) bad_gnt++;
            tick();
        end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL bp_core_ready: bad=%0d want 0", bad_rdy); end
        checks++; if (bad_vld !== 0) begin errors++; $display("FAIL bp_rsp_valid: bad=%0d want 0", bad_vld); end
        checks++; if (bad_dat !== 0) begin errors++; $display("FAIL bp_rsp_data: bad=%0d want 0", bad_dat); end
        checks++; if (bad_gnt !== 0) begin errors++; $display("FAIL bp_hold_wait: bad=%0d want 0", bad_gnt); end
        rsp_ready_i[3] = 1'b1;
        drive();
        checks++; if (core_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", core_ready_o); end
        tick();
        checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL bp_idle_after: got %b want 0000", grant_o); end
        checks++; if (rlog.size() !== 1) begin errors++; $display("FAIL bp_rsp_count: got %0d want 1", rlog.size()); end
    endtask

    task automatic test_errors();
        bit to;
        int e0;
        rsp_t q;
        beat_t b;
        blog.delete(); rlog.delete();
        e0 = err_cnt;
        spur = 1'b1;
        drive();
        checks++; if (core_ready_o !== 1'b1) begin errors++; $display("FAIL err_spur_drop: got %b want 1", core_ready_o); end
        checks++; if (rsp_valid_o !== 4'b0) begin errors++; $display("FAIL err_spur_rsp: got %b want 0000", rsp_valid_o); end
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_spur_pulse: got %b want 1", err_o); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_spur_end: got %b want 0", err_o); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL err_spur_width: got %0d want 1", err_cnt - e0); end
        e0 = err_cnt;
        start_msg(2, 50, 3, MODE_CONT);
        drive();
        run_rsp(1, 100, to);
        tick();
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL err_mode0_width: got %0d want 1", err_cnt - e0); end
        b = get_beat(0);
        checks++; if (b.mode !== MODE_CONT || b.data !== beat_data(2, 50, 0)) begin errors++; $display("FAIL err_mode0_fwd: got %b/%h want 00/%h", b.mode, b.data, beat_data(2, 50, 0)); end
        q = get_rsp(0);
        checks++; if (q.vld !== 4'b0100 || q.data !== golden(2, 50, 3)) begin errors++; $display("FAIL err_mode0_digest: got %b/%h want 0100/%h", q.vld, q.data[511:448], golden(2, 50, 3) >> 448); end
    endtask

    initial begin
        cyc = 0;
        err_cnt = 0;
        test_reset();
        test_single();
        test_all_rr();
        test_block_other();
        test_reset_mid();
        test_backpressure();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
